// File: rtl/indexmod_stream.sv
// -----------------------------------------------------------------------------
// indexmod_stream
//
// Streams the modular product sequence (A * i) mod N for i = 0 .. N-1.
// Each beat carries LANES consecutive products. A start handshake captures A.
// The first beat is valid on the following cycle. Further beats are produced
// with adders only: every lane advances by the registered step (A*LANES) mod N.
//
// Parameters
//   N      index range size (power of two, >= 2)
//   WIDTH  bit width of indices and products, default $clog2(N)
//   LANES  products per beat (power of two, 1 <= LANES <= N)
//
// Ports
//   clk, rst_n           clock and asynchronous active-low reset
//   start_valid/ready    request handshake; start_ready is high only in IDLE
//   a_in                 multiplicand A, captured on the start handshake
//   out_valid/ready      output beat handshake
//   out_s[LANES]         lane k = (A*(out_base+k)) mod N
//   out_base             index of lane 0 in the current beat
//   out_last             final beat of the sequence
//
// Build option
//   INDEXMOD_STREAM_BITREV_EN  when defined, each out_s lane is the WIDTH-bit
//                              bit-reversal of its product. This is wiring
//                              only, so it adds no logic and no latency.
// -----------------------------------------------------------------------------
module indexmod_stream #(
  parameter int N     = 8,
  parameter int WIDTH = $clog2(N),
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s [LANES-1:0],
  output logic [WIDTH-1:0] out_base,
  output logic             out_last
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // When LANES == N this truncates to 0. The sequence then has a single beat,
  // so the base never advances.
  localparam logic [WIDTH-1:0] LANES_W   = WIDTH'(LANES);
  localparam logic [WIDTH-1:0] LAST_BASE = WIDTH'(N - LANES);

  state_e           state_q;
  logic [WIDTH-1:0] step_q;              // (A*LANES) mod N
  logic [WIDTH-1:0] base_q;
  logic [WIDTH-1:0] lane_q [LANES-1:0];
  logic             last_q;

  // NOTE: all state below updates with non-blocking (<=) assignments so every
  // register samples the pre-edge values of the others. Blocking assignments
  // here would create order-dependent, simulation/synthesis-mismatched logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      base_q  <= '0;
      last_q  <= 1'b0;
      // NOTE: lane_q is a small register array, not a RAM. It is cleared on
      // reset so out_s reads 0 while reset is asserted. A true memory macro
      // would normally be left unreset.
      for (int k = 0; k < LANES; k++) lane_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            state_q <= RUN;
            // The only multiplications happen here, in the capture cycle.
            step_q  <= WIDTH'(a_in * LANES);
            base_q  <= '0;
            last_q  <= (LANES == N);
            for (int k = 0; k < LANES; k++) lane_q[k] <= WIDTH'(a_in * k);
          end
        end
        RUN: begin
          if (out_ready) begin
            if (last_q) begin
              // Last beat accepted: return to IDLE with clean outputs.
              state_q <= IDLE;
              step_q  <= '0;
              base_q  <= '0;
              last_q  <= 1'b0;
              for (int k = 0; k < LANES; k++) lane_q[k] <= '0;
            end else begin
              base_q <= base_q + LANES_W;
              last_q <= ((base_q + LANES_W) == LAST_BASE);
              for (int k = 0; k < LANES; k++) lane_q[k] <= lane_q[k] + step_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_ready = (state_q == IDLE);
  assign out_valid   = (state_q == RUN);
  assign out_base    = base_q;
  assign out_last    = last_q;

  // NOTE: every output of this always_comb gets a default value first, so no
  // path leaves it unassigned and no latch can be inferred.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      out_s[k] = '0;
`ifdef INDEXMOD_STREAM_BITREV_EN
      for (int b = 0; b < WIDTH; b++) out_s[k][b] = lane_q[k][WIDTH-1-b];
`else
      out_s[k] = lane_q[k];
`endif
    end
  end

endmodule

// File: tb/tb_indexmod_stream.sv
// -----------------------------------------------------------------------------
// tb_indexmod_stream
//
// Instantiates three copies of indexmod_stream with N=8: one with LANES=1,
// one with LANES=4 and one with LANES=8.
// Each started sequence pushes its expected beats into a scoreboard queue. The
// queue is popped as beats transfer. Outputs are sampled on the falling edge of
// clk, and inputs are also driven there.
// -----------------------------------------------------------------------------
module tb_indexmod_stream;

  localparam int N = 8;
  localparam int W = $clog2(N);
  localparam int LANES_OF [3] = '{1, 4, 8};

  typedef struct packed {
    logic [W-1:0]   base;
    logic           last;
    logic [N*W-1:0] s;
  } beat_t;

  logic clk;
  logic rst_n;

  logic         sv   [3];
  logic [W-1:0] ain  [3];
  logic         ordy [3];
  logic         srdy [3];
  logic         oval [3];
  logic [W-1:0] obase[3];
  logic         olast[3];

  logic [W-1:0] s1 [0:0];
  logic [W-1:0] s4 [3:0];
  logic [W-1:0] s8 [7:0];

  logic [N*W-1:0] obs_s [3];

  int n_cmp = 0;
  int n_err = 0;
  beat_t q[$];

  indexmod_stream #(.N(N), .LANES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(sv[0]), .start_ready(srdy[0]), .a_in(ain[0]),
    .out_valid(oval[0]), .out_ready(ordy[0]),
    .out_s(s1), .out_base(obase[0]), .out_last(olast[0])
  );

  indexmod_stream #(.N(N), .LANES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(sv[1]), .start_ready(srdy[1]), .a_in(ain[1]),
    .out_valid(oval[1]), .out_ready(ordy[1]),
    .out_s(s4), .out_base(obase[1]), .out_last(olast[1])
  );

  indexmod_stream #(.N(N), .LANES(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(sv[2]), .start_ready(srdy[2]), .a_in(ain[2]),
    .out_valid(oval[2]), .out_ready(ordy[2]),
    .out_s(s8), .out_base(obase[2]), .out_last(olast[2])
  );

  always_comb begin
    for (int i = 0; i < 3; i++) obs_s[i] = '0;
    obs_s[0][W-1:0] = s1[0];
    for (int k = 0; k < 4; k++) obs_s[1][k*W +: W] = s4[k];
    for (int k = 0; k < 8; k++) obs_s[2][k*W +: W] = s8[k];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product for one lane, computed directly from the definition.
  function automatic logic [W-1:0] exp_lane(input int a, input int idx);
    logic [W-1:0] v;
    logic [W-1:0] r;
    v = W'((a * idx) % N);
    r = v;
`ifdef INDEXMOD_STREAM_BITREV_EN
    for (int b = 0; b < W; b++) r[b] = v[W-1-b];
`endif
    return r;
  endfunction

  // Drives one sequence on instance inst and checks every beat against the
  // scoreboard.
  //   stall_beat/stall_len  hold out_ready low for stall_len cycles on that beat
  //   pulse_beat            pulse start_valid with a different A on that beat
  //   abort_beat            assert reset while that beat is presented
  // The task is entered and left on a falling edge.
  task automatic run_seq(input int inst, input int a, input int stall_beat,
                         input int stall_len, input int pulse_beat,
                         input int abort_beat, input string name);
    int    lanes;
    int    beats;
    int    beat;
    int    stall_left;
    int    cyc;
    bit    aborted;
    beat_t e;
    beat_t got;
    lanes   = LANES_OF[inst];
    beats   = N / lanes;
    aborted = 1'b0;

    n_cmp++;
    if (srdy[inst] !== 1'b1) begin
      n_err++;
      $display("FAIL %s start_ready before start: got %b want 1", name, srdy[inst]);
    end

    for (int b = 0; b < beats; b++) begin
      e.base = W'(b * lanes);
      e.last = (b == beats - 1);
      e.s    = '0;
      for (int k = 0; k < lanes; k++) e.s[k*W +: W] = exp_lane(a, b * lanes + k);
      q.push_back(e);
    end

    sv[inst]   = 1'b1;
    ain[inst]  = W'(a);
    ordy[inst] = 1'b1;
    @(negedge clk);
    sv[inst] = 1'b0;

    beat       = 0;
    stall_left = stall_len;
    cyc        = 0;
    while (q.size() > 0 && cyc < 200) begin
      cyc++;
      if (beat == abort_beat) begin
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({oval[inst], obase[inst], olast[inst], obs_s[inst]} !== '0) begin
          n_err++;
          $display("FAIL %s outputs in reset: valid=%b base=%0d last=%b s=%h want all 0",
                   name, oval[inst], obase[inst], olast[inst], obs_s[inst]);
        end
        q.delete();
        aborted = 1'b1;
        break;
      end
      n_cmp++;
      if (oval[inst] !== 1'b1) begin
        n_err++;
        $display("FAIL %s out_valid beat %0d: got %b want 1", name, beat, oval[inst]);
      end else begin
        got = '{base: obase[inst], last: olast[inst], s: obs_s[inst]};
        n_cmp++;
        if (got !== q[0]) begin
          n_err++;
          $display("FAIL %s beat %0d: got base=%0d last=%b s=%h want base=%0d last=%b s=%h",
                   name, beat, got.base, got.last, got.s, q[0].base, q[0].last, q[0].s);
        end
      end
      if (beat == pulse_beat) begin
        sv[inst]  = 1'b1;
        ain[inst] = W'(~a);
        n_cmp++;
        if (srdy[inst] !== 1'b0) begin
          n_err++;
          $display("FAIL %s start_ready during run: got %b want 0", name, srdy[inst]);
        end
      end else begin
        sv[inst] = 1'b0;
      end
      if (beat == stall_beat && stall_left > 0) begin
        ordy[inst] = 1'b0;
        stall_left--;
      end else begin
        ordy[inst] = 1'b1;
        void'(q.pop_front());
        beat++;
      end
      @(negedge clk);
    end
    sv[inst]   = 1'b0;
    ordy[inst] = 1'b1;

    if (aborted) begin
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        n_cmp++;
        if (oval[inst] !== 1'b0 || srdy[inst] !== 1'b1) begin
          n_err++;
          $display("FAIL %s after reset release: valid=%b ready=%b want 0/1",
                   name, oval[inst], srdy[inst]);
        end
      end
    end else begin
      n_cmp++;
      if (q.size() != 0) begin
        n_err++;
        $display("FAIL %s timeout: %0d beats outstanding want 0", name, q.size());
        q.delete();
      end
      n_cmp++;
      if (oval[inst] !== 1'b0 || srdy[inst] !== 1'b1) begin
        n_err++;
        $display("FAIL %s after last beat: valid=%b ready=%b want 0/1",
                 name, oval[inst], srdy[inst]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sv[i]   = 1'b0;
      ain[i]  = '0;
      ordy[i] = 1'b1;
    end
    #3;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({oval[i], obase[i], olast[i], obs_s[i]} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs inst %0d: valid=%b base=%0d last=%b s=%h want all 0",
                 i, oval[i], obase[i], olast[i], obs_s[i]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (srdy[i] !== 1'b1 || oval[i] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_release inst %0d: ready=%b valid=%b want 1/0", i, srdy[i], oval[i]);
      end
    end
  endtask

  task automatic test_sequence();
    run_seq(0, 3, -1, 0, -1, -1, "seq_a3_l1");
    run_seq(0, 7, -1, 0, -1, -1, "seq_a7_l1");
  endtask

  task automatic test_lanes();
    run_seq(1, 5, -1, 0, -1, -1, "seq_a5_l4");
    run_seq(1, 0, -1, 0, -1, -1, "seq_a0_l4");
    run_seq(1, 3, 0, 2, -1, -1, "seq_a3_l4_stall");
    run_seq(2, 3, -1, 0, -1, -1, "seq_a3_l8");
    run_seq(2, 6, 0, 2, -1, -1, "seq_a6_l8_stall");
  endtask

  task automatic test_stall_and_ignore();
    run_seq(0, 3, 2, 3, 4, -1, "stall_ignore_a3");
  endtask

  task automatic test_mid_run_reset();
    run_seq(0, 3, -1, 0, -1, 3, "abort_a3");
    run_seq(0, 1, -1, 0, -1, -1, "after_abort_a1");
  endtask

  task automatic test_back_to_back();
    run_seq(0, 5, -1, 0, -1, -1, "b2b_first_a5");
    run_seq(0, 2, 6, 1, -1, -1, "b2b_second_a2");
    run_seq(1, 7, -1, 0, 1, -1, "b2b_l4_a7");
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_lanes();
    test_stall_and_ignore();
    test_mid_run_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
